// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter with input FIFO, baud divider, runtime frame
//            format, frame-boundary CTS flow control and break generation.
// Revision : 1.0
// ============================================================================
module uart_tx_fifo #(
   parameter int MAX_DATA_BITS = 9,
   parameter int FIFO_DEPTH    = 8,
   parameter int DIV_WIDTH     = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DIV_WIDTH-1:0]            cfg_div,
   input  logic [3:0]                      cfg_data_bits,
   input  logic [1:0]                      cfg_parity,
   input  logic                            cfg_stop2,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [MAX_DATA_BITS-1:0]        s_data,
   input  logic                            cts,
   input  logic                            break_req,
   output logic                            tx_out,
   output logic                            tx_busy,
   output logic                            tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
   localparam int                   c_LVL_W   = $clog2(FIFO_DEPTH + 1);
   localparam int                   c_PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [c_LVL_W-1:0]   c_DEPTH   = c_LVL_W'(FIFO_DEPTH);
   localparam logic [c_PTR_W-1:0]   c_PTR_ONE = c_PTR_W'(1);
   localparam logic [DIV_WIDTH:0]   c_CNT_ONE = (DIV_WIDTH + 1)'(1);
   localparam logic [DIV_WIDTH-1:0] c_DIV_MIN = DIV_WIDTH'(2);
   localparam logic [3:0]           c_NB_MIN  = 4'd5;
   localparam logic [3:0]           c_NB_MAX  = 4'(MAX_DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2, S_BREAK, S_BRK_GUARD
   } state_t;

   logic [MAX_DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [c_PTR_W-1:0]       wptr_q, rptr_q;
   logic [c_LVL_W-1:0]       level_q;

   state_t                   state_q, state_d;
   logic [DIV_WIDTH:0]       cnt_q, cnt_d;
   logic [DIV_WIDTH-1:0]     div_q, div_d;
   logic [3:0]               nbits_q, nbits_d, idx_q, idx_d;
   logic                     par_en_q, par_en_d, par_bit_q, par_bit_d;
   logic                     stop2_q, stop2_d, tx_q, tx_d, busy_q, busy_d;
   logic [MAX_DATA_BITS-1:0] shift_q, shift_d;

   logic                     push, pop, eval, done, bit_end, guard_end;
   logic [DIV_WIDTH-1:0]     div_eff;
   logic [3:0]               nbits_eff;
   logic [MAX_DATA_BITS-1:0] head, head_masked;

   assign s_ready    = !rst && (level_q < c_DEPTH);
   assign push       = s_valid && s_ready;
   assign head       = mem_q[rptr_q];
   assign div_eff    = (cfg_div < c_DIV_MIN) ? c_DIV_MIN : cfg_div;
   assign nbits_eff  = (cfg_data_bits < c_NB_MIN) ? c_NB_MIN :
                       (cfg_data_bits > c_NB_MAX) ? c_NB_MAX : cfg_data_bits;
   assign bit_end    = (cnt_q == ({1'b0, div_q} - c_CNT_ONE));
   assign guard_end  = (cnt_q == ({div_q, 1'b0} - c_CNT_ONE));

   always_comb begin
      head_masked = '0;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         head_masked[i] = head[i] & (4'(i) < nbits_eff);
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q + c_CNT_ONE;
      div_d     = div_q;
      nbits_d   = nbits_q;
      idx_d     = idx_q;
      par_en_d  = par_en_q;
      par_bit_d = par_bit_q;
      stop2_d   = stop2_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      pop       = 1'b0;
      eval      = 1'b0;
      done      = 1'b0;

      case (state_q)
         S_IDLE: eval = 1'b1;
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               cnt_d   = '0;
               tx_d    = shift_q[0];
               shift_d = shift_q >> 1;
               idx_d   = '0;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (idx_q == nbits_q - 4'd1) begin
                  state_d = par_en_q ? S_PARITY : S_STOP1;
                  tx_d    = par_en_q ? par_bit_q : 1'b1;
               end else begin
                  tx_d    = shift_q[0];
                  shift_d = shift_q >> 1;
                  idx_d   = idx_q + 4'd1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP1;
               cnt_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_STOP1: begin
            if (bit_end) begin
               cnt_d = '0;
               if (stop2_q) begin
                  state_d = S_STOP2;
               end else begin
                  done = 1'b1;
                  eval = 1'b1;
               end
            end
         end
         S_STOP2: begin
            if (bit_end) begin
               done = 1'b1;
               eval = 1'b1;
            end
         end
         S_BREAK: begin
            if (!break_req) begin
               state_d = S_BRK_GUARD;
               cnt_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_BRK_GUARD: eval = guard_end;
         default: state_d = S_IDLE;
      endcase

      // Shared decision point: idle, last cycle of a frame, end of break guard.
      if (eval) begin
         if (break_req) begin
            state_d = S_BREAK;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
            div_d   = div_eff;
         end else if ((level_q != '0) && cts) begin
            pop       = 1'b1;
            state_d   = S_START;
            cnt_d     = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            div_d     = div_eff;
            nbits_d   = nbits_eff;
            par_en_d  = (cfg_parity != 2'b00);
            par_bit_d = (cfg_parity == 2'b11) ? 1'b1 : ((^head_masked) ^ cfg_parity[1]);
            stop2_d   = cfg_stop2;
            shift_d   = head_masked;
            idx_d     = '0;
         end else begin
            state_d = S_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wptr_q] <= s_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q    <= '0;
         rptr_q    <= '0;
         level_q   <= '0;
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         div_q     <= c_DIV_MIN;
         nbits_q   <= c_NB_MIN;
         idx_q     <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         stop2_q   <= 1'b0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         if (push) wptr_q <= wptr_q + c_PTR_ONE;
         if (pop)  rptr_q <= rptr_q + c_PTR_ONE;
         level_q   <= level_q + c_LVL_W'(push) - c_LVL_W'(pop);
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         div_q     <= div_d;
         nbits_q   <= nbits_d;
         idx_q     <= idx_d;
         par_en_q  <= par_en_d;
         par_bit_q <= par_bit_d;
         stop2_q   <= stop2_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   assign tx_out     = tx_q;
   assign tx_busy    = busy_q;
   assign tx_done    = done;
   assign fifo_level = level_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_fifo
// Brief    : Self-checking bench for uart_tx_fifo against a waveform-queue model.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_fifo;
   localparam int MAXB = 9;
   localparam int DEPTH = 8;
   localparam int DW = 16;
   localparam int M_IDLE = 0, M_FRAME = 1, M_GUARD = 2, M_BREAK = 3;

   typedef bit bitq_t[$];

   logic            clk = 1'b0;
   logic            rst;
   logic [DW-1:0]   cfg_div;
   logic [3:0]      cfg_data_bits;
   logic [1:0]      cfg_parity;
   logic            cfg_stop2;
   logic            s_valid, s_ready;
   logic [MAXB-1:0] s_data;
   logic            cts, break_req;
   logic            tx_out, tx_busy, tx_done;
   logic [3:0]      fifo_level;

   always #5 clk = ~clk;

   uart_tx_fifo #(.MAX_DATA_BITS(MAXB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .cfg_div(cfg_div), .cfg_data_bits(cfg_data_bits),
      .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .s_valid(s_valid),
      .s_ready(s_ready), .s_data(s_data), .cts(cts), .break_req(break_req),
      .tx_out(tx_out), .tx_busy(tx_busy), .tx_done(tx_done), .fifo_level(fifo_level)
   );

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: each started frame becomes a queue of per-cycle line levels.
   logic [MAXB-1:0] m_fifo[$];
   bit              m_wave[$];
   int              m_mode = M_IDLE;
   int              m_div = 2;

   function automatic int eff_div(input int d);
      return (d < 2) ? 2 : d;
   endfunction

   function automatic int eff_nb(input int n);
      return (n < 5) ? 5 : ((n > MAXB) ? MAXB : n);
   endfunction

   function automatic bitq_t frame_bits(input logic [MAXB-1:0] w, input int nb,
                                        input int par, input bit st2);
      bitq_t b;
      bit    x = 1'b0;
      b.push_back(1'b0);
      for (int i = 0; i < nb; i++) begin
         b.push_back(w[i]);
         x ^= w[i];
      end
      if (par == 1) b.push_back(x);
      else if (par == 2) b.push_back(!x);
      else if (par == 3) b.push_back(1'b1);
      b.push_back(1'b1);
      if (st2) b.push_back(1'b1);
      return b;
   endfunction

   always @(posedge clk or posedge rst) begin : model
      bit              ev, pushok;
      bitq_t           fb;
      logic [MAXB-1:0] w;
      if (rst) begin
         m_fifo.delete();
         m_wave.delete();
         m_mode = M_IDLE;
      end else begin
         pushok = s_valid && (m_fifo.size() < DEPTH);
         ev = (m_mode == M_IDLE) || (m_mode != M_BREAK && m_wave.size() == 1);
         if (m_mode == M_BREAK) begin
            if (!break_req) begin
               m_mode = M_GUARD;
               m_wave.delete();
               repeat (2 * m_div) m_wave.push_back(1'b1);
            end
         end else if (ev) begin
            m_wave.delete();
            if (break_req) begin
               m_mode = M_BREAK;
               m_div = eff_div(int'(cfg_div));
            end else if (m_fifo.size() > 0 && cts) begin
               w = m_fifo.pop_front();
               fb = frame_bits(w, eff_nb(int'(cfg_data_bits)), int'(cfg_parity), cfg_stop2);
               foreach (fb[k]) repeat (eff_div(int'(cfg_div))) m_wave.push_back(fb[k]);
               m_mode = M_FRAME;
            end else begin
               m_mode = M_IDLE;
            end
         end else begin
            void'(m_wave.pop_front());
         end
         if (pushok) m_fifo.push_back(s_data);
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         chk("tx_out", 32'(tx_out),
             32'((m_mode == M_BREAK) ? 1'b0 : ((m_wave.size() > 0) ? m_wave[0] : 1'b1)));
         chk("tx_busy", 32'(tx_busy), 32'(m_mode != M_IDLE));
         chk("tx_done", 32'(tx_done), 32'(m_mode == M_FRAME && m_wave.size() == 1));
         chk("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
         chk("s_ready", 32'(s_ready), 32'(m_fifo.size() < DEPTH));
      end
   end

   int cyc = 0, busy_cnt = 0, done_cnt = 0, low_cnt = 0;
   int first_busy = -1, last_busy = -1, done_at = -1;
   bit cap_en = 1'b0;
   bit cap_tx[$];
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (tx_busy === 1'b1) begin
            busy_cnt++;
            if (first_busy < 0) first_busy = cyc;
            last_busy = cyc;
            if (cap_en) cap_tx.push_back(tx_out);
         end
         if (tx_done === 1'b1) begin
            done_cnt++;
            done_at = cyc;
         end
         if (tx_out === 1'b0) low_cnt++;
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic set_cfg(input int dv, input int nb, input int par, input bit st2);
      cfg_div = DW'(dv);
      cfg_data_bits = 4'(nb);
      cfg_parity = 2'(par);
      cfg_stop2 = st2;
   endtask

   task automatic clear_stats();
      busy_cnt = 0; done_cnt = 0; low_cnt = 0;
      first_busy = -1; last_busy = -1; done_at = -1;
      cap_tx.delete();
   endtask

   task automatic push_word(input logic [MAXB-1:0] w);
      bit acc = 1'b0;
      s_valid = 1'b1;
      s_data = w;
      for (int i = 0; i < 2000 && !acc; i++) begin
         acc = s_ready;
         step();
      end
      s_valid = 1'b0;
      chk("push_accept", 32'(acc), 32'd1);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (!tx_busy && (fifo_level == 0 || !cts)) break;
         step();
      end
      chk("idle_reached", 32'(tx_busy), 32'd0);
   endtask

   task automatic run_frame(input string tag, input logic [MAXB-1:0] w,
                            input int dv, input int exp_bits[11]);
      clear_stats();
      cap_en = 1'b1;
      push_word(w);
      repeat (dv * 11 + 16) step();
      cap_en = 1'b0;
      chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(dv * 11));
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_last_cycle"}, 32'(done_at - first_busy), 32'(dv * 11 - 1));
      for (int b = 0; b < 11; b++) begin
         chk({tag, "_bit"}, (b * dv + 1 < cap_tx.size()) ? 32'(cap_tx[b * dv + 1]) : 32'hx,
             32'(exp_bits[b]));
      end
   endtask

   function automatic int pack_bits(input bitq_t b);
      int v = 0;
      foreach (b[k]) v |= int'(b[k]) << k;
      return v;
   endfunction

   int e1[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
   int e2[11] = '{0, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};

   initial begin
      int brk_left = 0;
      int d0;
      bit acc;
      rst = 1'b1; s_valid = 1'b0; s_data = '0; cts = 1'b1; break_req = 1'b0;
      set_cfg(4, 8, 1, 0);

      // Pin the model's frame builder to hand-computed sequences.
      chk("model_a5_8e1", 32'(pack_bits(frame_bits(9'h0A5, 8, 1, 0))), 32'd1354);
      chk("model_55_7o2", 32'(pack_bits(frame_bits(9'h055, 7, 2, 1))), 32'd1962);
      chk("model_1ff_9m2", 32'(pack_bits(frame_bits(9'h1FF, 9, 3, 1))), 32'd8190);

      repeat (3) step();
      chk("rst_tx_out", 32'(tx_out), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_done", 32'(tx_done), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      rst = 1'b0;
      chk_en = 1'b1;
      step();
      chk("s_ready_after_rst", 32'(s_ready), 32'd1);

      set_cfg(4, 8, 1, 0);
      run_frame("t1", 9'h0A5, 4, e1);
      set_cfg(2, 7, 2, 1);
      run_frame("t2", 9'h055, 2, e2);

      // CTS held low: fill FIFO, then release and expect 9 back-to-back frames.
      set_cfg(2, 8, 0, 0);
      cts = 1'b0;
      for (int w = 1; w <= 8; w++) push_word(MAXB'(w));
      s_valid = 1'b1; s_data = 9'h009;
      repeat (5) step();
      chk("t4_level_full", 32'(fifo_level), 32'd8);
      chk("t4_s_ready_low", 32'(s_ready), 32'd0);
      chk("t4_tx_idle", 32'(tx_out), 32'd1);
      clear_stats();
      cts = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 500 && !acc; i++) begin
         acc = s_ready;
         step();
      end
      s_valid = 1'b0;
      chk("t4_ninth_accept", 32'(acc), 32'd1);
      wait_idle(2000);
      chk("t4_span", 32'(last_busy - first_busy + 1), 32'd180);
      chk("t4_done", 32'(done_cnt), 32'd9);

      // CTS drop mid-frame: current frame completes, next word held.
      clear_stats();
      push_word(9'h033);
      push_word(9'h044);
      repeat (3) step();
      cts = 1'b0;
      wait_idle(200);
      repeat (10) step();
      chk("t5_held_level", 32'(fifo_level), 32'd1);
      chk("t5_held_busy", 32'(tx_busy), 32'd0);
      chk("t5_first_done", 32'(done_cnt), 32'd1);
      cts = 1'b1;
      wait_idle(200);
      chk("t5_total_done", 32'(done_cnt), 32'd2);

      // Break while idle, word queued during break.
      set_cfg(4, 8, 0, 0);
      clear_stats();
      break_req = 1'b1;
      step();
      push_word(9'h05A);
      repeat (48) step();
      break_req = 1'b0;
      repeat (8) step();
      chk("t6_low_cycles", 32'(low_cnt), 32'd50);
      chk("t6_guard_high", 32'(tx_out), 32'd1);
      chk("t6_guard_busy", 32'(tx_busy), 32'd1);
      chk("t6_no_done", 32'(done_cnt), 32'd0);
      step();
      chk("t6_start_bit", 32'(tx_out), 32'd0);
      chk("t6_popped", 32'(fifo_level), 32'd0);
      wait_idle(200);
      chk("t6_done", 32'(done_cnt), 32'd1);

      // Asynchronous reset in the middle of a data bit with 3 words queued.
      cts = 1'b0;
      for (int w = 0; w < 4; w++) push_word(MAXB'(9'h011 + w));
      cts = 1'b1;
      repeat (8) step();
      chk("t8_level_before", 32'(fifo_level), 32'd3);
      chk("t8_busy_before", 32'(tx_busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("t8_async_tx", 32'(tx_out), 32'd1);
      chk("t8_async_level", 32'(fifo_level), 32'd0);
      chk("t8_async_ready", 32'(s_ready), 32'd0);
      chk("t8_async_busy", 32'(tx_busy), 32'd0);
      repeat (2) step();
      rst = 1'b0;
      clear_stats();
      repeat (100) step();
      chk("t8_no_frame", 32'(busy_cnt), 32'd0);

      // Randomised traffic, flow control, breaks and mid-frame config changes.
      for (int i = 0; i < 4000; i++) begin
         s_valid = ($urandom_range(0, 3) != 0);
         s_data = MAXB'($urandom);
         if ($urandom_range(0, 99) == 0) cts = ~cts;
         if (brk_left > 0) begin
            brk_left--;
            break_req = 1'b1;
         end else begin
            break_req = 1'b0;
            if ($urandom_range(0, 399) == 0) brk_left = $urandom_range(1, 20);
         end
         if ($urandom_range(0, 59) == 0)
            set_cfg($urandom_range(0, 4), $urandom_range(0, 15),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
         step();
      end
      s_valid = 1'b0; break_req = 1'b0; cts = 1'b1;
      repeat (2) step();
      d0 = done_cnt;
      wait_idle(20000);
      chk("rand_drained", 32'(fifo_level), 32'd0);
      chk("rand_done_seen", 32'(done_cnt >= d0), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
